// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - PC register and instruction fetch sequencer for the RV32I core
// Fetches at pc, presents the word until commit, then advances or redirects.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned MAX_WAIT     = 15
) (
  input  logic        clk2,
  input  logic        reset2,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        commit,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] mepc
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);
  localparam logic [CW-1:0] WAIT_SAT  = {CW{1'b1}};

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_TRAP
  } state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [CW-1:0] wait_cnt;

  assign pc_out    = pc;
  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  always_ff @(posedge clk2) begin
    if (reset2) begin
      state       <= S_IDLE;
      pc          <= RESET_VECTOR;
      wait_cnt    <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= 32'd0;
      trap        <= 1'b0;
      trap_cause  <= 2'b00;
      mepc        <= 32'd0;
    end else begin
      trap <= 1'b0;
      case (state)
        S_IDLE: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
          wait_cnt <= '0;
        end

        // ready beats a simultaneous timeout
        S_FETCH: begin
          if (imem_ready) begin
            instr       <= imem_rdata;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= S_ISSUE;
          end else if (wait_cnt == WAIT_LAST) begin
            imem_req   <= 1'b0;
            trap       <= 1'b1;
            trap_cause <= CAUSE_TIMEOUT;
            mepc       <= pc;
            state      <= S_TRAP;
          end else if (wait_cnt != WAIT_SAT) begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end

        S_ISSUE: begin
          if (commit && !stall) begin
            instr_valid <= 1'b0;
            wait_cnt    <= '0;
            if (!branch_taken) begin
              pc       <= pc + 32'd4;
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end else if (branch_target[1:0] == 2'b00) begin
              pc       <= branch_target;
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end else begin
              trap       <= 1'b1;
              trap_cause <= CAUSE_MISALIGN;
              mepc       <= pc;
              state      <= S_TRAP;
            end
          end
        end

        S_TRAP: begin
          pc       <= TRAP_VECTOR;
          imem_req <= 1'b1;
          wait_cnt <= '0;
          state    <= S_FETCH;
        end

        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
